nn_sld_ctrl: RTL and testbench
==============================

Name: nn_sld_ctrl

Overview:
- Sequencer for the 6x6 sliding image register file.
- Fetches 48-bit column words (6 pixels) from the image buffer in row-major order.
- Drives the register file's shift/mode/half-select controls and presents a valid window to the PE array with a valid/ready handshake.
- Sits between the layer-config/top controller and the sliding register file plus PE array.

Parameters:
- ADDR_WIDTH, 10, image buffer word-address width
- DIM_WIDTH, 8, width of the image column-count and row-band-count fields

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle start pulse; accepted only in IDLE
- i_mode  in  2  kernel mode: 00 = 3x3 (half-register), 01/10/11 = 6-wide full-register slide
- i_img_w  in  DIM_WIDTH  column words per row-band
- i_img_h  in  DIM_WIDTH  number of row-bands
- i_base_addr  in  ADDR_WIDTH  buffer address of the first column word
- i_pe_ready  in  1  PE array consumes the current window
- o_rd_en  out  1  buffer read strobe; data returns exactly 1 cycle later
- o_rd_addr  out  ADDR_WIDTH  buffer read address
- o_shift  out  1  shift strobe to the register file
- o_mode  out  2  latched mode to the register file
- o_3x3  out  1  half select for mode 00 (1 = high half)
- o_win_valid  out  1  register file holds a complete window
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle job-complete pulse
- o_err  out  1  sticky config error; cleared on next accepted start

Behaviour:
- Reset: every output is 0. The FSM goes to IDLE and all counters clear. Reset mid-job aborts the job immediately with no done pulse.
- Configuration:
  - Mode, width, height and base address are latched on an accepted start. Inputs are don't-care afterwards.
  - An i_start while busy is ignored.
- Fill depth: FILL = 3 in mode 00, otherwise 6. Windows per band = i_img_w - FILL + 1. Total windows = that value × i_img_h.
- Config error: if i_img_w < FILL or i_img_h == 0:
  - No reads are issued.
  - o_err = 1 and o_done pulses in the cycle after start.
  - FSM returns to IDLE; o_busy stays 0.
- States: IDLE -> FILL -> WIN -> (FILL | STEP | DONE) -> IDLE.
  - FILL: issue FILL back-to-back reads, one per cycle. Address is a running counter starting at i_base_addr, +1 per read, and it never resets between bands. Wrap modulo 2^ADDR_WIDTH.
  - Read-to-shift: o_shift is o_rd_en delayed by exactly one register stage. Every read produces exactly one shift.
  - WIN: entered the cycle after the last fill/step shift. o_win_valid stays high until i_pe_ready is sampled high. No shift or read occurs while a window is held.
  - On a handshake in cycle t:
    - If columns remain in the band: STEP issues one read at t+1, shift at t+2, o_win_valid again at t+3.
    - If the band is exhausted and bands remain: go to FILL. First read at t+1. In mode 00, o_3x3 toggles at t+1.
    - If this was the last window: o_done pulses at t+1, o_busy falls at t+1, FSM to IDLE.
- Latency from start: i_start at cycle 0 -> o_rd_en cycles 1..FILL -> o_shift cycles 2..FILL+1 -> o_win_valid at FILL+2.
- o_busy: 1 from cycle 1 until the done cycle.
- o_3x3: 1 for the first band of every job, then alternates per band. It is held constant within a band and forced to 1 when o_mode != 00.
- o_mode: constant throughout a job.
- i_pe_ready while o_win_valid = 0 is ignored.
- i_img_w = FILL: one window per band, and every band transition is a refill.
- Counters: DIM_WIDTH bits. The windows-per-band compare is unsigned and must not underflow; the error check runs first.

Decomposition:
- Shared package nn_sld_pkg holds:
  - mode encodings MODE_3X3 = 2'b00, MODE_FULL_*;
  - FILL_3X3 = 3, FILL_FULL = 6;
  - the FSM state enum (IDLE, FILL, WIN, STEP, DONE).
- Optional sub-module nn_sld_addr_gen: the running read-address counter plus column and band counters, with a "band_last"/"job_last" flag interface.
- The top holds the FSM and handshake.

Test Plan:
- Mode 01, w=8, h=1, base=0x010, pe_ready tied 1:
  - reads cycles 1..6 at addresses 0x010..0x015;
  - first o_win_valid at cycle 8;
  - 3 windows total, done pulse after the third handshake;
  - last address 0x017.
- Mode 00, w=4, h=2:
  - 3 fills then 1 step in band 0 with o_3x3 = 1;
  - refill of 3 in band 1 with o_3x3 = 0;
  - 4 windows total, reads cover 0..7 contiguous.
- Back-pressure: hold i_pe_ready = 0 for 5 cycles in WIN -> o_win_valid steady, no o_rd_en/o_shift; release -> read next cycle, valid 3 cycles after the handshake.
- Errors:
  - mode 01, w=5 -> o_err = 1, o_done at cycle 1, zero reads;
  - h=0 -> same;
  - next valid start clears o_err.
- Ignored start and reset:
  - i_start pulsed mid-job -> no effect on addresses or counts;
  - assert i_rst during FILL -> all outputs 0 next edge; a subsequent start restarts from base.
- Address wrap: ADDR_WIDTH=10, base=0x3FE, mode 01, w=6 -> addresses 0x3FE, 0x3FF, 0x000..0x003.

Source files
------------

// File: rtl/nn_sld_pkg.sv
// Shared types and constants for the sliding-window sequencer.
// Mode encodings, fill depths and the sequencer FSM state enum.
package nn_sld_pkg;

  localparam logic [1:0] MODE_3X3    = 2'b00;
  localparam logic [1:0] MODE_FULL_A = 2'b01;
  localparam logic [1:0] MODE_FULL_B = 2'b10;
  localparam logic [1:0] MODE_FULL_C = 2'b11;

  localparam logic [2:0] FILL_3X3  = 3'd3;
  localparam logic [2:0] FILL_FULL = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WIN,
    STEP,
    DONE
  } state_t;

  function automatic logic [2:0] fill_depth(input logic [1:0] m);
    return (m == MODE_3X3) ? FILL_3X3 : FILL_FULL;
  endfunction

endpackage

// File: rtl/nn_sld_addr_gen.sv
// Running read address plus column/band counters for the sequencer.
// Ports: i_load/i_base_addr/i_img_w/i_img_h/i_fill latch a job; i_rd, i_step, i_band advance; o_addr, o_band_last, o_job_last.
module nn_sld_addr_gen
  import nn_sld_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [DIM_WIDTH-1:0]  i_img_w,
  input  logic [DIM_WIDTH-1:0]  i_img_h,
  input  logic [2:0]            i_fill,
  input  logic                  i_rd,
  input  logic                  i_step,
  input  logic                  i_band,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_band_last,
  output logic                  o_job_last
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DIM_WIDTH-1:0]  span_q;
  logic [DIM_WIDTH-1:0]  hl_q;
  logic [DIM_WIDTH-1:0]  col_q;
  logic [DIM_WIDTH-1:0]  band_q;

  // span/hl are only used when the config passed the error check,
  // so the subtractions cannot underflow on a live job.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_q <= '0;
      span_q <= '0;
      hl_q   <= '0;
      col_q  <= '0;
      band_q <= '0;
    end else if (i_load) begin
      addr_q <= i_base_addr;
      span_q <= i_img_w - DIM_WIDTH'(i_fill);
      hl_q   <= i_img_h - 1'b1;
      col_q  <= '0;
      band_q <= '0;
    end else begin
      if (i_rd)
        addr_q <= addr_q + 1'b1;
      if (i_step)
        col_q <= col_q + 1'b1;
      if (i_band) begin
        col_q  <= '0;
        band_q <= band_q + 1'b1;
      end
    end
  end

  assign o_addr      = addr_q;
  assign o_band_last = (col_q == span_q);
  assign o_job_last  = o_band_last && (band_q == hl_q);

endmodule

// File: rtl/nn_sld_ctrl.sv
// Sliding image register file sequencer: fetch, shift, window handshake.
// Ports: i_start/i_mode/i_img_w/i_img_h/i_base_addr config; i_pe_ready; o_rd_*, o_shift, o_mode, o_3x3, o_win_valid, o_busy, o_done, o_err.
module nn_sld_ctrl
  import nn_sld_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [DIM_WIDTH-1:0]  i_img_w,
  input  logic [DIM_WIDTH-1:0]  i_img_h,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic                  i_pe_ready,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_shift,
  output logic [1:0]            o_mode,
  output logic                  o_3x3,
  output logic                  o_win_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  state_t     state_q, state_d;
  logic [2:0] pcnt_q, pcnt_d;
  logic [2:0] fill_q;
  logic [1:0] mode_q;
  logic       half_q;
  logic       err_q;
  logic       shift_q;
  logic       rd_en, step, band;
  logic       band_last, job_last;
  logic       accept, cfg_bad;
  logic [2:0] fill_in;

  assign fill_in = fill_depth(i_mode);
  assign cfg_bad = (i_img_w < DIM_WIDTH'(fill_in)) ||
                   (i_img_h == '0);
  assign accept  = (state_q == IDLE) && i_start;

  nn_sld_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (accept),
    .i_base_addr (i_base_addr),
    .i_img_w     (i_img_w),
    .i_img_h     (i_img_h),
    .i_fill      (fill_in),
    .i_rd        (rd_en),
    .i_step      (step),
    .i_band      (band),
    .o_addr      (o_rd_addr),
    .o_band_last (band_last),
    .o_job_last  (job_last)
  );

  // FILL/STEP each hold one extra cycle after their last read so the
  // registered shift lands before the window is presented.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    rd_en   = 1'b0;
    step    = 1'b0;
    band    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          pcnt_d  = '0;
          state_d = cfg_bad ? DONE : FILL;
        end
      end
      FILL: begin
        rd_en = (pcnt_q < fill_q);
        if (pcnt_q == fill_q)
          state_d = WIN;
        else
          pcnt_d = pcnt_q + 1'b1;
      end
      STEP: begin
        rd_en = (pcnt_q == '0);
        if (pcnt_q == 3'd1)
          state_d = WIN;
        else
          pcnt_d = pcnt_q + 1'b1;
      end
      WIN: begin
        if (i_pe_ready) begin
          pcnt_d = '0;
          if (!band_last) begin
            step    = 1'b1;
            state_d = STEP;
          end else if (!job_last) begin
            band    = 1'b1;
            state_d = FILL;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      fill_q  <= '0;
      mode_q  <= '0;
      half_q  <= 1'b0;
      err_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      shift_q <= rd_en;
      if (accept) begin
        mode_q <= i_mode;
        fill_q <= fill_in;
        half_q <= 1'b1;
        err_q  <= cfg_bad;
      end else if (band && (mode_q == MODE_3X3)) begin
        half_q <= ~half_q;
      end
    end
  end

  assign o_rd_en     = rd_en;
  assign o_shift     = shift_q;
  assign o_mode      = mode_q;
  assign o_3x3       = half_q;
  assign o_win_valid = (state_q == WIN);
  assign o_busy      = (state_q == FILL) ||
                       (state_q == WIN)  ||
                       (state_q == STEP);
  assign o_done      = (state_q == DONE);
  assign o_err       = err_q;

endmodule

// File: tb/tb_nn_sld_ctrl.sv
// Directed self-checking bench for nn_sld_ctrl.
// Drives config/handshake, checks cycle timing, addresses and flags.
module tb_nn_sld_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] img_w, img_h;
  logic [9:0] base;
  logic       pe_ready;
  logic       rd_en, shift, win_valid, busy, done, err, h3;
  logic [9:0] rd_addr;
  logic [1:0] mode_o;

  int n_chk = 0;
  int n_err = 0;

  logic       mon_clr = 1'b0;
  int         n_rd, n_sh, n_win, n_done;
  logic [9:0] rd_log [0:15];

  always #5 clk = ~clk;

  nn_sld_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_mode      (mode),
    .i_img_w     (img_w),
    .i_img_h     (img_h),
    .i_base_addr (base),
    .i_pe_ready  (pe_ready),
    .o_rd_en     (rd_en),
    .o_rd_addr   (rd_addr),
    .o_shift     (shift),
    .o_mode      (mode_o),
    .o_3x3       (h3),
    .o_win_valid (win_valid),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  always @(posedge clk) begin
    if (mon_clr) begin
      n_rd <= 0; n_sh <= 0; n_win <= 0; n_done <= 0;
    end else begin
      if (rd_en) begin
        if (n_rd < 16) rd_log[n_rd] <= rd_addr;
        n_rd <= n_rd + 1;
      end
      if (shift) n_sh <= n_sh + 1;
      if (win_valid && pe_ready) n_win <= n_win + 1;
      if (done) n_done <= n_done + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    cyc();
    mon_clr = 1'b0;
  endtask

  task automatic start_job(input logic [1:0] m, input logic [7:0] w,
                           input logic [7:0] h, input logic [9:0] b);
    mode = m; img_w = w; img_h = h; base = b;
    start = 1'b1;
    cyc();
    start = 1'b0;
    mode = 2'b11; img_w = 8'hff; img_h = 8'hff; base = 10'h2aa;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      cyc();
    end
    chk(tag, done, 1);
    cyc();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 0; img_w = 0; img_h = 0;
    base = 0; pe_ready = 1'b0;
    #2;
    chk("rst_outs", {rd_en, shift, win_valid, busy, done, err, h3,
                     mode_o, rd_addr}, 0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // mode 01, w=8, h=1, ready tied high
    pe_ready = 1'b1;
    clr();
    start_job(2'b01, 8'd8, 8'd1, 10'h010);
    for (int c = 1; c <= 15; c++) begin
      logic e_rd, e_sh, e_v;
      logic [9:0] e_a;
      e_rd = (c <= 6) || (c == 9) || (c == 12);
      e_sh = (c >= 2 && c <= 7) || (c == 10) || (c == 13);
      e_v  = (c == 8) || (c == 11) || (c == 14);
      e_a  = (c <= 6) ? 10'(10'h010 + c - 1) :
             (c == 9) ? 10'h016 : 10'h017;
      chk($sformatf("t1_rd_c%0d", c), rd_en, e_rd);
      if (e_rd) chk($sformatf("t1_addr_c%0d", c), rd_addr, e_a);
      chk($sformatf("t1_sh_c%0d", c), shift, e_sh);
      chk($sformatf("t1_v_c%0d", c), win_valid, e_v);
      chk($sformatf("t1_done_c%0d", c), done, c == 15);
      chk($sformatf("t1_busy_c%0d", c), busy, c <= 14);
      if (c == 8) chk("t1_3x3", h3, 1);
      if (c == 8) chk("t1_mode", mode_o, 2'b01);
      cyc();
    end
    chk("t1_nrd", n_rd, 8);
    chk("t1_nsh", n_sh, 8);
    chk("t1_nwin", n_win, 3);

    // mode 00, w=4, h=2
    clr();
    start_job(2'b00, 8'd4, 8'd2, 10'h000);
    for (int c = 1; c <= 17; c++) begin
      if (c == 5) begin
        chk("t2_v5", win_valid, 1);
        chk("t2_3x3_b0", h3, 1);
        chk("t2_mode", mode_o, 2'b00);
      end
      if (c == 6) chk("t2_step_addr", {rd_en, rd_addr}, {1'b1, 10'd3});
      if (c == 9) begin
        chk("t2_refill", {rd_en, rd_addr}, {1'b1, 10'd4});
        chk("t2_3x3_b1", h3, 0);
      end
      if (c == 13) chk("t2_v13", win_valid, 1);
      if (c == 16) chk("t2_3x3_hold", h3, 0);
      if (c == 17) chk("t2_done", done, 1);
      cyc();
    end
    chk("t2_nrd", n_rd, 8);
    chk("t2_nwin", n_win, 4);
    chk("t2_nsh", n_sh, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_log%0d", i), rd_log[i], i);

    // back-pressure: mode 01, w=7, h=1
    pe_ready = 1'b0;
    clr();
    start_job(2'b01, 8'd7, 8'd1, 10'h020);
    for (int c = 1; c < 8; c++) cyc();
    for (int c = 8; c <= 12; c++) begin
      chk($sformatf("t3_hold_c%0d", c), {win_valid, rd_en, shift},
          3'b100);
      cyc();
    end
    pe_ready = 1'b1;
    chk("t3_v13", win_valid, 1);
    cyc();
    chk("t3_rd14", {rd_en, rd_addr, win_valid}, {1'b1, 10'h026, 1'b0});
    cyc();
    chk("t3_sh15", {shift, rd_en}, 2'b10);
    cyc();
    chk("t3_v16", win_valid, 1);
    cyc();
    chk("t3_done17", {done, busy}, 2'b10);
    cyc();

    // config errors
    clr();
    start_job(2'b01, 8'd5, 8'd1, 10'h000);
    chk("t4a_c1", {err, done, busy, rd_en}, 4'b1100);
    cyc();
    chk("t4a_c2", {err, done, busy}, 3'b100);
    chk("t4a_nrd", n_rd, 0);
    start_job(2'b01, 8'd8, 8'd0, 10'h000);
    chk("t4b_c1", {err, done, busy, rd_en}, 4'b1100);
    cyc();
    chk("t4b_nrd", n_rd, 0);

    // wrap, err clear, ignored mid-job start
    clr();
    start_job(2'b01, 8'd6, 8'd1, 10'h3fe);
    chk("t5_errclr", err, 0);
    chk("t5_busy", busy, 1);
    cyc(); cyc();
    start = 1'b1; base = 10'h155; img_w = 8'd20;
    cyc();
    start = 1'b0;
    wait_done("t5_done");
    chk("t5_idle", busy, 0);
    chk("t5_nrd", n_rd, 6);
    chk("t5_nwin", n_win, 1);
    chk("t5_a0", rd_log[0], 10'h3fe);
    chk("t5_a1", rd_log[1], 10'h3ff);
    chk("t5_a2", rd_log[2], 10'h000);
    chk("t5_a5", rd_log[5], 10'h003);

    // reset during FILL
    clr();
    start_job(2'b01, 8'd8, 8'd1, 10'h050);
    cyc(); cyc();
    #2 rst = 1'b0;
    #1;
    chk("t6_rst", {rd_en, shift, win_valid, busy, done, err, h3,
                   mode_o, rd_addr}, 0);
    cyc();
    rst = 1'b1;
    cyc();
    start_job(2'b01, 8'd6, 8'd1, 10'h100);
    chk("t6_restart", {rd_en, rd_addr}, {1'b1, 10'h100});
    wait_done("t6_done");
    chk("t6_nrd", n_rd, 8);
    chk("t6_ndone", n_done, 1);
    chk("t6_log", rd_log[2], 10'h100);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
